// File: rtl/axi4lite_regfile_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_regfile_slave_if
// Description : AXI4-Lite bus bundle between a master and the register-file
//               slave. Carries the five AXI4-Lite channels; clock and reset
//               stay outside the interface as plain module ports.
// Parameters  : DATA_W - data bus width in bits (32 or 64)
//               ADDR_W - byte address width
// Signals     : AW_VALID/AW_READY/AW_ADDR   write address channel
//               W_VALID/W_READY/W_DATA/W_STRB write data channel
//               B_VALID/B_READY/B_RESP      write response channel
//               AR_VALID/AR_READY/AR_ADDR   read address channel
//               R_VALID/R_READY/R_DATA/R_RESP read data channel
// Modports    : master - drives VALIDs/payload, BREADY, RREADY
//               slave  - drives READYs, B/R responses
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4lite_regfile_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  AW_VALID;
    logic                  AW_READY;
    logic [ADDR_W-1:0]     AW_ADDR;
    logic                  W_VALID;
    logic                  W_READY;
    logic [DATA_W-1:0]     W_DATA;
    logic [DATA_W/8-1:0]   W_STRB;
    logic                  B_VALID;
    logic                  B_READY;
    logic [1:0]            B_RESP;
    logic                  AR_VALID;
    logic                  AR_READY;
    logic [ADDR_W-1:0]     AR_ADDR;
    logic                  R_VALID;
    logic                  R_READY;
    logic [DATA_W-1:0]     R_DATA;
    logic [1:0]            R_RESP;

    modport master (
        output AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY,
               R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AW_VALID, AW_ADDR, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY,
               R_VALID, R_DATA, R_RESP
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_regfile_slave
// Description : AXI4-Lite slave exposing NUM_REGS read/write registers.
//               Write address and write data are accepted independently and
//               held until both are present; the register is written on the
//               edge where the second one arrives. Reads are registered with
//               one cycle latency. Out-of-range accesses answer SLVERR.
// Parameters  : DATA_W   - data width (32 or 64)
//               ADDR_W   - byte address width
//               NUM_REGS - number of registers
// Ports       : A_CLK    - clock, rising edge
//               A_RSTn   - asynchronous active-low reset
//               s_axi    - AXI4-Lite slave modport
//               regs_o   - all registers, register i at [i*DATA_W +: DATA_W]
// Options     : AXI4LITE_WSTRB_EN - when defined, only strobed byte lanes
//               are written; otherwise W_STRB is ignored and writes update
//               the whole word.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_regfile_slave #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                       A_CLK,
    input  logic                       A_RSTn,
    axi4lite_regfile_slave_if.slave    s_axi,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);
    localparam int               c_NBYTES      = DATA_W / 8;
    localparam int               c_OFF_W       = $clog2(c_NBYTES);
    localparam int               c_IDX_W       = ADDR_W - c_OFF_W;
    localparam logic [c_IDX_W:0] c_NUM_REGS    = (c_IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0]       c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]       c_RESP_SLVERR = 2'b10;

    // Held write address / data (each waits for its partner)
    logic                r_aw_held;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic                r_w_held;
    logic [DATA_W-1:0]   r_w_data;
    logic [c_NBYTES-1:0] r_w_strb;

    // Response channels
    logic                r_b_valid;
    logic [1:0]          r_b_resp;
    logic                r_r_valid;
    logic [DATA_W-1:0]   r_r_data;
    logic [1:0]          r_r_resp;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [c_NBYTES-1:0] w_wr_strb;
    logic [c_NBYTES-1:0] w_byte_en;
    logic [c_IDX_W-1:0]  w_wr_idx;
    logic                w_wr_in_range;
    logic                w_wr_fire;
    logic [c_IDX_W-1:0]  w_rd_idx;
    logic                w_rd_in_range;
    logic [DATA_W-1:0]   w_rd_data;

    // READYs depend only on registered state, so no READY-to-VALID path.
    assign s_axi.AW_READY = !r_aw_held && !r_b_valid;
    assign s_axi.W_READY  = !r_w_held && !r_b_valid;
    assign s_axi.AR_READY = !r_r_valid;
    assign s_axi.B_VALID  = r_b_valid;
    assign s_axi.B_RESP   = r_b_resp;
    assign s_axi.R_VALID  = r_r_valid;
    assign s_axi.R_DATA   = r_r_data;
    assign s_axi.R_RESP   = r_r_resp;

    assign w_aw_hs = s_axi.AW_VALID && s_axi.AW_READY;
    assign w_w_hs  = s_axi.W_VALID  && s_axi.W_READY;
    assign w_b_hs  = r_b_valid      && s_axi.B_READY;
    assign w_ar_hs = s_axi.AR_VALID && s_axi.AR_READY;
    assign w_r_hs  = r_r_valid      && s_axi.R_READY;

    // A held beat takes precedence; otherwise the beat arriving this cycle.
    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axi.AW_ADDR;
    assign w_wr_data = r_w_held  ? r_w_data  : s_axi.W_DATA;
    assign w_wr_strb = r_w_held  ? r_w_strb  : s_axi.W_STRB;

    // Both halves present (held or arriving now) -> commit on this edge.
    assign w_wr_fire     = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_idx      = w_wr_addr[ADDR_W-1:c_OFF_W];
    assign w_wr_in_range = {1'b0, w_wr_idx} < c_NUM_REGS;

`ifdef AXI4LITE_WSTRB_EN
    assign w_byte_en = w_wr_strb;
`else
    // Strobes are ignored: every byte lane is forced on.
    assign w_byte_en = w_wr_strb | {c_NBYTES{1'b1}};
`endif

    assign w_rd_idx      = s_axi.AR_ADDR[ADDR_W-1:c_OFF_W];
    assign w_rd_in_range = {1'b0, w_rd_idx} < c_NUM_REGS;

    // Read mux over the current register contents; an index with no match
    // (out of range) yields zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == c_IDX_W'(i)) begin
                w_rd_data = regs_o[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
            logic [DATA_W-1:0] r_reg;

            always_ff @(posedge A_CLK or negedge A_RSTn) begin
                if (!A_RSTn) begin
                    r_reg <= '0;
                end else if (w_wr_fire && w_wr_in_range &&
                             (w_wr_idx == c_IDX_W'(g))) begin
                    for (int k = 0; k < c_NBYTES; k++) begin
                        if (w_byte_en[k]) begin
                            r_reg[8*k +: 8] <= w_wr_data[8*k +: 8];
                        end
                    end
                end
            end

            assign regs_o[g*DATA_W +: DATA_W] = r_reg;
        end
    endgenerate

    // Write channel: hold AW / W until the partner arrives, then respond.
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_b_valid <= 1'b0;
            r_b_resp  <= c_RESP_OKAY;
        end else begin
            if (w_wr_fire) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= s_axi.AW_ADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= s_axi.W_DATA;
                    r_w_strb <= s_axi.W_STRB;
                end
            end
            // A new write cannot fire while B is pending, so no conflict.
            if (w_b_hs) begin
                r_b_valid <= 1'b0;
            end
        end
    end

    // Read channel: data is sampled from the registers before any write on
    // the same edge lands, so a colliding read returns the old value.
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= c_RESP_OKAY;
        end else if (w_ar_hs) begin
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_data;
            r_r_resp  <= w_rd_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
        end else if (w_r_hs) begin
            r_r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire
